encoder_angle_proc: RTL

Parametrised electrical-angle processor between the absolute-encoder serial reader and the Cordic sin/cos generator in the FOC datapath. On each completed encoder read it captures the single-turn position, scales it by a configurable pole-pair count, applies direction inversion and an electrical zero offset, and issues a one-cycle strobe to start the Cordic. It also produces a wrap-aware per-sample mechanical speed delta and a stale-data flag when reads stop arriving.

---
 rtl/encoder_angle_proc.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/encoder_angle_proc.sv
// encoder_angle_proc: encoder position -> electrical angle for the Cordic, plus
// stale-data watchdog and optional per-sample speed delta.
// Optional feature macro: SPEED_EST_EN (speed delta path; oSpeed tied to 0 when undefined).
module encoder_angle_proc #(
  parameter int unsigned POS_W       = 20,
  parameter int unsigned POLE_PAIRS  = 5,
  parameter int unsigned SPD_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic                    iEn,
  input  logic                    iPos_done,
  input  logic [POS_W-1:0]        iPos,
  input  logic [POS_W-1:0]        iOffset,
  input  logic                    iDir_inv,
  output logic [POS_W-1:0]        oTheta_elec,
  output logic                    oTheta_valid,
  output logic signed [SPD_W-1:0] oSpeed,
  output logic                    oStale
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic             done_d1;
  logic             done_d2;
  logic             accept;

  logic             s0_valid;
  logic [POS_W-1:0] s0_pos;
  logic [POS_W-1:0] s0_off;
  logic             s0_dir;

  logic             s1_valid;
  logic [POS_W-1:0] s1_prod;
  logic [POS_W-1:0] s1_off;
  logic             s1_dir;

  logic [POS_W-1:0] oriented;
  logic [POS_W-1:0] theta_nxt;

  logic [CNT_W-1:0] stale_cnt;

  // Rising edge of the registered read-done level, gated by enable
  assign accept = done_d1 & ~done_d2 & iEn;

  // Read-done edge detector
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      done_d1 <= 1'b0;
      done_d2 <= 1'b0;
    end else begin
      done_d1 <= iPos_done;
      done_d2 <= done_d1;
    end
  end

  // S0: capture position, offset and direction on an accepted edge
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s0_valid <= 1'b0;
      s0_pos   <= '0;
      s0_off   <= '0;
      s0_dir   <= 1'b0;
    end else begin
      s0_valid <= accept;
      if (accept) begin
        s0_pos <= iPos;
        s0_off <= iOffset;
        s0_dir <= iDir_inv;
      end
    end
  end

  // S1: scale by pole pairs; only the low POS_W bits (one electrical turn) matter,
  // so the product is formed directly at POS_W width
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_off   <= '0;
      s1_dir   <= 1'b0;
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_prod <= POS_W'(s0_pos * POS_W'(POLE_PAIRS));
        s1_off  <= s0_off;
        s1_dir  <= s0_dir;
      end
    end
  end

  // S2 combinational: direction inversion then zero offset, modulo 2^POS_W
  always_comb begin
    oriented  = s1_dir ? (POS_W'(0) - s1_prod) : s1_prod;
    theta_nxt = oriented - s1_off;
  end

  // S2: register angle and strobe the Cordic
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oTheta_elec  <= '0;
      oTheta_valid <= 1'b0;
    end else begin
      oTheta_valid <= s1_valid;
      if (s1_valid) begin
        oTheta_elec <= theta_nxt;
      end
    end
  end

  // Stale watchdog; an accepted edge beats a coincident timeout
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stale_cnt <= '0;
      oStale    <= 1'b0;
    end else if (!iEn || accept) begin
      stale_cnt <= '0;
      oStale    <= 1'b0;
    end else if (stale_cnt != CNT_W'(TIMEOUT_CYC)) begin
      stale_cnt <= stale_cnt + CNT_W'(1);
      oStale    <= (stale_cnt == CNT_W'(TIMEOUT_CYC - 1));
    end
  end

`ifdef SPEED_EST_EN
  localparam logic signed [POS_W-1:0] SPD_MAX =
    {{(POS_W - SPD_W + 1){1'b0}}, {(SPD_W - 1){1'b1}}};
  localparam logic signed [POS_W-1:0] SPD_MIN =
    {{(POS_W - SPD_W + 1){1'b1}}, {(SPD_W - 1){1'b0}}};

  logic [POS_W-1:0]        s1_pos;
  logic [POS_W-1:0]        pos_prev;
  logic                    prev_valid;
  logic signed [POS_W-1:0] delta;
  logic signed [SPD_W-1:0] delta_sat;

  // Carry the raw position alongside the scaled one
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s1_pos <= '0;
    end else if (s0_valid) begin
      s1_pos <= s0_pos;
    end
  end

  // Short-way wrapped delta, saturated to the speed width
  always_comb begin
    delta     = $signed(s1_pos - pos_prev);
    delta_sat = SPD_W'(delta);
    if (delta > SPD_MAX) begin
      delta_sat = SPD_W'(SPD_MAX);
    end else if (delta < SPD_MIN) begin
      delta_sat = SPD_W'(SPD_MIN);
    end
  end

  // Speed output and history; stale invalidates history and zeroes speed
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oSpeed     <= '0;
      pos_prev   <= '0;
      prev_valid <= 1'b0;
    end else if (s1_valid) begin
      oSpeed     <= prev_valid ? delta_sat : '0;
      pos_prev   <= s1_pos;
      prev_valid <= 1'b1;
    end else if (oStale) begin
      oSpeed     <= '0;
      prev_valid <= 1'b0;
    end
  end
`else
  // No speed estimation built
  assign oSpeed = '0;
`endif

endmodule
